// File: rtl/input_deserializer.sv
// Serial-to-parallel receiver, LSB first, with a double-buffered held word and a
// ready/loaddata handshake. Define PARITY_CHECK_EN for frames with a trailing even-parity bit.
module input_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             loaddata,
  input  logic             overrun_clr,
  output logic             inputdata_ready,
  output logic [WIDTH-1:0] inputdata,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_data;
  logic             r_ready;
  logic             r_ov;

  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_ov_set;

  assign w_last = (r_cnt == CW'(FRAME - 1));
  assign w_done = serial_valid & w_last;

`ifdef PARITY_CHECK_EN
  logic r_perr;
  logic w_perr;
  // Data bits are already complete in the shift register when the parity bit arrives.
  assign w_word     = r_sr;
  assign w_perr     = (^r_sr) ^ serial_in;
  assign parity_err = r_perr;
`else
  // The last data bit is folded in directly so the word is loaded on the same edge.
  assign w_word = {serial_in, r_sr[WIDTH-1:1]};
`endif

  assign w_ov_set = w_done & (r_state == S_FULL) & ~loaddata;

  // Shift path: never stalls, only serial_valid advances it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (serial_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef PARITY_CHECK_EN
      if (!w_last) r_sr <= {serial_in, r_sr[WIDTH-1:1]};
`else
      r_sr <= {serial_in, r_sr[WIDTH-1:1]};
`endif
    end
  end

  // Holding FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_ov    <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ov <= (r_ov & ~overrun_clr) | w_ov_set;
      case (r_state)
        S_EMPTY: begin
          if (w_done) begin
            r_data  <= w_word;
            r_state <= S_FULL;
            r_ready <= 1'b1;
`ifdef PARITY_CHECK_EN
            r_perr  <= w_perr;
`endif
          end
        end
        S_FULL: begin
          if (w_done && loaddata) begin
            r_data <= w_word;
`ifdef PARITY_CHECK_EN
            r_perr <= w_perr;
`endif
          end else if (loaddata) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign inputdata_ready = r_ready;
  assign inputdata       = r_data;
  assign overrun         = r_ov;

endmodule

// File: doc/input_deserializer.md
Name: input_deserializer

Overview:
- Producer side of the loaddata/inputdata_ready handshake.
- Assembles a serial bit stream into a WIDTH-bit word and holds it in an output register.
- Raises inputdata_ready while a word is held; a one-cycle loaddata pulse from the control unit consumes it.
- Double-buffered: reception of the next word continues while the held word waits.

Parameters:
- WIDTH, 8, data word width in bits (2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- serial_in  input  1  serial data bit, LSB first.
- serial_valid  input  1  serial_in is sampled on the rising edge where this is 1.
- loaddata  input  1  consume strobe from the control unit; 1 = held word taken this cycle.
- overrun_clr  input  1  synchronous clear of the overrun flag.
- inputdata_ready  output  1  1 = inputdata holds an unconsumed word.
- inputdata  output  WIDTH  held data word.
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - inputdata_ready=0, inputdata=0, overrun=0.
  - Bit counter=0, shift register=0, state=EMPTY.
  - Reset mid-word discards the partial word.
- Shift path:
  - Each edge with serial_valid=1 shifts serial_in into the shift register (LSB first) and increments bit_cnt.
  - At bit_cnt=WIDTH-1 with serial_valid=1 the word is complete ("done"); bit_cnt wraps to 0 on the same edge.
  - serial_valid=0 holds the shift register and bit_cnt; gaps are allowed anywhere.
- Holding state machine:
  - EMPTY (inputdata_ready=0):
    - done -> inputdata <= completed word; go to FULL.
    - inputdata_ready is 1 in the cycle after the last bit is sampled (latency 1 clock from last bit edge).
    - loaddata in EMPTY: ignored, no effect.
  - FULL (inputdata_ready=1):
    - loaddata=1, no done -> EMPTY; inputdata_ready=0 the next cycle; inputdata keeps its last value.
    - loaddata=1 and done on the same edge -> inputdata <= new word; stay FULL. No overrun, no ready gap.
    - done, loaddata=0 -> new word dropped; inputdata unchanged; overrun <= 1.
- Invariants:
  - inputdata is stable whenever inputdata_ready=1, except on the simultaneous loaddata+done edge.
  - Receiving never stalls; there is no back-pressure on the serial side.
- Overrun:
  - Sticky; cleared only by reset or overrun_clr=1.
  - If overrun_clr=1 and a new overrun occur on the same edge, overrun stays 1 (set wins).
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; done is raised on the parity bit.
  - Extra output port parity_err (1 bit, reset 0), updated only when a word is loaded into inputdata: 1 if the XOR of the data bits and the parity bit is 1.
  - Words with bad parity are still delivered.
- Undefined:
  - Frames are WIDTH bits; no parity_err port exists.

Test Plan:
- Reset/basic: hold reset=0 for 3 cycles, release, stream 0xA5 LSB first with serial_valid=1 for 8 cycles -> inputdata_ready=1 one cycle after the 8th bit, inputdata=0xA5, overrun=0. Pulse loaddata -> inputdata_ready=0 next cycle.
- Gapped input: send 0x3C with serial_valid toggling 1,0,1,0... -> inputdata=0x3C after 8 valid bits; bit_cnt does not advance on valid=0 cycles.
- Overrun: send 0x11, no loaddata, then send 0x22 -> inputdata stays 0x11, overrun=1. Pulse overrun_clr -> overrun=0.
- Simultaneous: hold 0x55, assert loaddata on the edge sampling the last bit of 0x66 -> inputdata=0x66, inputdata_ready remains 1 with no gap, overrun=0.
- Reset mid-operation: after 4 bits of 0xF0, pull reset=0 -> all outputs 0 immediately (asynchronous). Then send 0x81 -> inputdata=0x81, showing the partial word was discarded.
- PARITY_CHECK_EN: frame 0x07 with parity bit 1 -> parity_err=0. Frame 0x07 with parity bit 0 -> parity_err=1, inputdata=0x07.
